// File: rtl/speed_ctrl.sv
// Button-driven speed selector: debounced press steps SLOW/MED/FAST(/PAUSE) and a prescaler emits tick.
// Define SPEED_CTRL_PAUSE_EN to include the PAUSE mode; without it the mode loops SLOW->MED->FAST.
module speed_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int DIV_SLOW   = 50000000,
    parameter int DIV_MED    = 25000000,
    parameter int DIV_FAST   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       tick,
    output logic [1:0] mode,
    output logic       paused,
    output logic       press
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DIV_MAX = max_of(DIV_SLOW, max_of(DIV_MED, DIV_FAST));
    localparam int PW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int DW      = $clog2(DEB_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES);
    localparam logic [PW-1:0] LIM_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] LIM_MED  = PW'(DIV_MED - 1);
    localparam logic [PW-1:0] LIM_FAST = PW'(DIV_FAST - 1);

    localparam logic [1:0] MODE_SLOW  = 2'b00;
    localparam logic [1:0] MODE_MED   = 2'b01;
    localparam logic [1:0] MODE_FAST  = 2'b10;
`ifdef SPEED_CTRL_PAUSE_EN
    localparam logic [1:0] MODE_PAUSE = 2'b11;
`endif

    logic          sync_meta;
    logic          sync_btn;
    logic          stable;
    logic [DW-1:0] deb_cnt;
    logic          accept_press;
    logic [1:0]    next_mode;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_lim;
    logic          prescale_hold;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            sync_btn  <= 1'b1;
        end else begin
            sync_meta <= btn;
            sync_btn  <= sync_meta;
        end
    end

    // A new level is adopted on the edge after it has differed for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable  <= 1'b1;
            deb_cnt <= '0;
        end else if (sync_btn == stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            stable  <= sync_btn;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    assign accept_press = stable && !sync_btn && (deb_cnt == DEB_LAST);

    always_comb begin
        next_mode = MODE_SLOW;
        case (mode)
            MODE_SLOW: next_mode = MODE_MED;
            MODE_MED:  next_mode = MODE_FAST;
`ifdef SPEED_CTRL_PAUSE_EN
            MODE_FAST: next_mode = MODE_PAUSE;
`endif
            default:   next_mode = MODE_SLOW;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode  <= MODE_SLOW;
            press <= 1'b0;
        end else begin
            press <= accept_press;
            if (accept_press) begin
                mode <= next_mode;
            end
        end
    end

`ifdef SPEED_CTRL_PAUSE_EN
    assign paused        = (mode == MODE_PAUSE);
    assign prescale_hold = (mode == MODE_PAUSE);
`else
    assign paused        = 1'b0;
    assign prescale_hold = 1'b0;
`endif

    always_comb begin
        presc_lim = LIM_SLOW;
        case (mode)
            MODE_MED:  presc_lim = LIM_MED;
            MODE_FAST: presc_lim = LIM_FAST;
            default:   presc_lim = LIM_SLOW;
        endcase
    end

    // A mode change restarts the count and swallows any tick due on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (accept_press || prescale_hold) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc >= presc_lim) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + PW'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_speed_ctrl.sv
// Directed self-checking bench for speed_ctrl with small debounce and divider parameters.
// Expected values follow SPEED_CTRL_PAUSE_EN the same way the design does.
module tb_speed_ctrl;

    localparam int DEB = 4;
    localparam int DS  = 8;
    localparam int DM  = 4;
    localparam int DF  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b1;
    logic       tick;
    logic [1:0] mode;
    logic       paused;
    logic       press;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    speed_ctrl #(
        .DEB_CYCLES(DEB),
        .DIV_SLOW(DS),
        .DIV_MED(DM),
        .DIV_FAST(DF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .tick(tick),
        .mode(mode),
        .paused(paused),
        .press(press)
    );

    function automatic logic [1:0] mode_after(input int presses);
`ifdef SPEED_CTRL_PAUSE_EN
        return 2'(presses % 4);
`else
        return 2'(presses % 3);
`endif
    endfunction

    function automatic int div_of(input logic [1:0] m);
        case (m)
            2'b00:   return DS;
            2'b01:   return DM;
            2'b10:   return DF;
            default: return 1;
        endcase
    endfunction

    // Reset is released on a falling edge, so the next negedge follows edge 1.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        btn = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tick got=%b exp=0", tick); end
        vectors++;
        if (mode !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mode got=%b exp=00", mode); end
        vectors++;
        if (paused !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_paused got=%b exp=0", paused); end
        vectors++;
        if (press !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_press got=%b exp=0", press); end
        reset = 1'b1;
    endtask

    task automatic test_idle();
        logic exp_tick;
        btn = 1'b1;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_tick = (n % DS == 0);
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL idle_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
            vectors++;
            if (mode !== 2'b00 || press !== 1'b0) begin
                miscompares++; $display("[TB] FAIL idle_mode_press n=%0d got=%b/%b exp=00/0", n, mode, press);
            end
        end
    endtask

    task automatic test_press();
        logic exp_tick, exp_press;
        logic [1:0] exp_mode;
        btn = 1'b1;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_press = (n == 9);
            exp_mode  = (n >= 9) ? 2'b01 : 2'b00;
            exp_tick  = (n < 9) ? (n % DS == 0) : (n > 9 && (n - 9) % DM == 0);
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL press_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
            vectors++;
            if (press !== exp_press) begin miscompares++; $display("[TB] FAIL press_pulse n=%0d got=%b exp=%b", n, press, exp_press); end
            vectors++;
            if (mode !== exp_mode) begin miscompares++; $display("[TB] FAIL press_mode n=%0d got=%b exp=%b", n, mode, exp_mode); end
            if (n == 2) btn = 1'b0;
            if (n == 22) btn = 1'b1;
        end
    endtask

    task automatic test_bounce();
        logic exp_tick;
        btn = 1'b1;
        do_reset();
        btn = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_tick = (n % DS == 0);
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL bounce_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
            vectors++;
            if (press !== 1'b0 || mode !== 2'b00) begin
                miscompares++; $display("[TB] FAIL bounce_mode_press n=%0d got=%b/%b exp=00/0", n, mode, press);
            end
            btn = (n < 25 && (n % 5) < 3) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_mode_cycle();
        int idx, m;
        logic [1:0] exp_mode;
        logic exp_tick, exp_press;
        btn = 1'b1;
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            idx = 0;
            exp_press = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (n >= 20 * k + 9) idx = k + 1;
                if (n == 20 * k + 9) exp_press = 1'b1;
            end
            m = (idx > 0) ? 20 * (idx - 1) + 9 : 0;
            exp_mode = mode_after(idx);
            exp_tick = (exp_mode != 2'b11) && (n > m) && ((n - m) % div_of(exp_mode) == 0);
            vectors++;
            if (mode !== exp_mode) begin miscompares++; $display("[TB] FAIL cycle_mode n=%0d got=%b exp=%b", n, mode, exp_mode); end
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL cycle_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
            vectors++;
            if (press !== exp_press) begin miscompares++; $display("[TB] FAIL cycle_press n=%0d got=%b exp=%b", n, press, exp_press); end
            vectors++;
            if (paused !== (exp_mode == 2'b11)) begin
                miscompares++; $display("[TB] FAIL cycle_paused n=%0d got=%b exp=%b", n, paused, exp_mode == 2'b11);
            end
            for (int k = 0; k < 4; k++) begin
                if (n == 20 * k + 2) btn = 1'b0;
                if (n == 20 * k + 12) btn = 1'b1;
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic exp_tick, exp_press;
        logic [1:0] exp_mode;
        btn = 1'b0;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_press = (n == 7);
            exp_mode  = (n >= 7) ? 2'b01 : 2'b00;
            exp_tick  = (n > 7) && ((n - 7) % DM == 0);
            vectors++;
            if (press !== exp_press) begin miscompares++; $display("[TB] FAIL held_press n=%0d got=%b exp=%b", n, press, exp_press); end
            vectors++;
            if (mode !== exp_mode) begin miscompares++; $display("[TB] FAIL held_mode n=%0d got=%b exp=%b", n, mode, exp_mode); end
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL held_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
        end
        btn = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic exp_tick;
        btn = 1'b1;
        do_reset();
        for (int n = 1; n <= 46; n++) begin
            @(negedge clk);
            if (n == 40) begin
                vectors++;
                if (mode !== 2'b10) begin miscompares++; $display("[TB] FAIL mid_pre_mode got=%b exp=10", mode); end
            end
            if (n == 2 || n == 22 || n == 42) btn = 1'b0;
            if (n == 12 || n == 32) btn = 1'b1;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (mode !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_mode got=%b exp=00", mode); end
        vectors++;
        if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_tick got=%b exp=0", tick); end
        vectors++;
        if (press !== 1'b0 || paused !== 1'b0) begin
            miscompares++; $display("[TB] FAIL mid_press_paused got=%b/%b exp=0/0", press, paused);
        end
        btn = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            exp_tick = (n % DS == 0);
            vectors++;
            if (press !== 1'b0 || mode !== 2'b00) begin
                miscompares++; $display("[TB] FAIL mid_after n=%0d got=%b/%b exp=00/0", n, mode, press);
            end
            vectors++;
            if (tick !== exp_tick) begin miscompares++; $display("[TB] FAIL mid_after_tick n=%0d got=%b exp=%b", n, tick, exp_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_mode_cycle();
        test_held_through_reset();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
